// File: rtl/roc_ddr_pkg.sv
// Shared encodings for the TEMPFIFO -> DDR3 write scheduler.
// Optional partial-burst flush is enabled by defining TEMPFIFO_FLUSH_EN.
package roc_ddr_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    FULL = 3'd4
  } wrState_e;

  localparam int WORD_BYTES = 8;
  localparam int LEN_W      = 9;

endpackage

// File: rtl/ddr_wr_addr_gen.sv
// Burst address and committed-word counters for the DDR write scheduler,
// plus the region-full look-ahead compare. Unaffected by TEMPFIFO_FLUSH_EN.
module ddr_wr_addr_gen
  import roc_ddr_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0] MEM_WORDS = 32'h100000
) (
  input  logic              digiclk_i,
  input  logic              reset,
  input  logic              rewind_i,
  input  logic              commit_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       words_o,
  output logic              fullNext_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       words_q, words_d;
  logic [32:0]       wordsAhead;

  always_comb begin
    addr_d  = addr_q;
    words_d = words_q;
    if (rewind_i) begin
      addr_d  = BASE_ADDR;
      words_d = '0;
    end else if (commit_i) begin
      addr_d  = addr_q + ADDR_W'(len_i) * ADDR_W'(WORD_BYTES);
      words_d = words_q + 32'(len_i);
    end
  end

  // Room check for the burst after the one being committed now.
  assign wordsAhead = {1'b0, words_q} + 33'(len_i) + 33'(BURST_LEN);
  assign fullNext_o = wordsAhead > {1'b0, MEM_WORDS};

  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset) begin
      addr_q  <= BASE_ADDR;
      words_q <= '0;
    end else begin
      addr_q  <= addr_d;
      words_q <= words_d;
    end
  end

  assign addr_o  = addr_q;
  assign words_o = words_q;

endmodule

// File: rtl/tempfifo_ddr_wr_sched.sv
// Drains the FWFT TEMPFIFO into DDR3 as fixed-length write bursts.
// Define TEMPFIFO_FLUSH_EN to allow flush_i to issue a short burst.
module tempfifo_ddr_wr_sched
  import roc_ddr_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 11,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0] MEM_WORDS = 32'h100000
) (
  input  logic              digiclk_i,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              restart_i,
  input  logic              flush_i,
  input  logic [CNT_W-1:0]  tempfifo_rdcnt,
  input  logic              tempfifo_empty,
  input  logic [63:0]       tempfifo_data,
  output logic              tempfifo_re,
  output logic              wr_req_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [LEN_W-1:0]  wr_len_o,
  input  logic              wr_ack_i,
  output logic              wr_valid_o,
  output logic [63:0]       wr_data_o,
  input  logic              wr_ready_i,
  input  logic              wr_done_i,
  output logic              last_write_o,
  output logic [31:0]       words_written_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] BurstCnt = CNT_W'(BURST_LEN);
  localparam logic [LEN_W-1:0] LenBurst = LEN_W'(BURST_LEN);

  wrState_e         state_q;
  logic             wrReq_q;
  logic [LEN_W-1:0] wrLen_q;
  logic [LEN_W-1:0] beatCnt_q;
  logic             lastWrite_q;
  logic             beat;
  logic             rewind;
  logic             commit;
  logic             fullNext;
  logic             fullBurstReady;

`ifdef TEMPFIFO_FLUSH_EN
  logic flushReady;
  assign flushReady = enable_i && flush_i && (tempfifo_rdcnt != '0) &&
                      (tempfifo_rdcnt < BurstCnt);
`else
  logic unusedFlush;
  assign unusedFlush = flush_i;
`endif

  assign fullBurstReady = enable_i && (tempfifo_rdcnt >= BurstCnt);
  assign beat   = (state_q == DATA) && !tempfifo_empty && wr_ready_i;
  assign rewind = restart_i && ((state_q == IDLE) || (state_q == FULL));
  assign commit = (state_q == RESP) && wr_done_i;

  always_ff @(posedge digiclk_i or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wrReq_q     <= 1'b0;
      wrLen_q     <= LenBurst;
      beatCnt_q   <= '0;
      lastWrite_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (restart_i) begin
            lastWrite_q <= 1'b0;
          end else if (fullBurstReady) begin
            state_q   <= REQ;
            wrReq_q   <= 1'b1;
            wrLen_q   <= LenBurst;
            beatCnt_q <= '0;
`ifdef TEMPFIFO_FLUSH_EN
          end else if (flushReady) begin
            state_q   <= REQ;
            wrReq_q   <= 1'b1;
            wrLen_q   <= LEN_W'(tempfifo_rdcnt);
            beatCnt_q <= '0;
`endif
          end
        end
        REQ: begin
          if (wr_ack_i) begin
            state_q <= DATA;
            wrReq_q <= 1'b0;
          end
        end
        DATA: begin
          if (beat) begin
            if (beatCnt_q == wrLen_q - LEN_W'(1)) begin
              state_q   <= RESP;
              beatCnt_q <= '0;
            end else begin
              beatCnt_q <= beatCnt_q + LEN_W'(1);
            end
          end
        end
        RESP: begin
          if (wr_done_i) begin
            if (fullNext) begin
              state_q     <= FULL;
              lastWrite_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        FULL: begin
          if (restart_i) begin
            state_q     <= IDLE;
            lastWrite_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          wrReq_q <= 1'b0;
        end
      endcase
    end
  end

  ddr_wr_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN),
    .BASE_ADDR (BASE_ADDR),
    .MEM_WORDS (MEM_WORDS)
  ) u_addr_gen (
    .digiclk_i  (digiclk_i),
    .reset      (reset),
    .rewind_i   (rewind),
    .commit_i   (commit),
    .len_i      (wrLen_q),
    .addr_o     (wr_addr_o),
    .words_o    (words_written_o),
    .fullNext_o (fullNext)
  );

  assign tempfifo_re  = beat;
  assign wr_valid_o   = (state_q == DATA) && !tempfifo_empty;
  assign wr_data_o    = tempfifo_data;
  assign wr_req_o     = wrReq_q;
  assign wr_len_o     = wrLen_q;
  assign last_write_o = lastWrite_q;
  assign busy_o       = (state_q == REQ) || (state_q == DATA) || (state_q == RESP);

endmodule

// File: tb/tb_tempfifo_ddr_wr_sched.sv
// Directed bench for tempfifo_ddr_wr_sched with a 32-word region so the full condition is reachable.
// Compile with TEMPFIFO_FLUSH_EN defined to exercise the short-burst flush path.
module tb_tempfifo_ddr_wr_sched;

  logic        digiclk_i;
  logic        reset;
  logic        enable_i;
  logic        restart_i;
  logic        flush_i;
  logic [10:0] tempfifo_rdcnt;
  logic        tempfifo_empty;
  logic [63:0] tempfifo_data;
  logic        tempfifo_re;
  logic        wr_req_o;
  logic [31:0] wr_addr_o;
  logic [8:0]  wr_len_o;
  logic        wr_ack_i;
  logic        wr_valid_o;
  logic [63:0] wr_data_o;
  logic        wr_ready_i;
  logic        wr_done_i;
  logic        last_write_o;
  logic [31:0] words_written_o;
  logic        busy_o;

  int          vecCount = 0;
  int          missCount = 0;

  logic [63:0] fifoQ[$];
  logic        fifoStall = 1'b0;
  logic [63:0] nextPush = 64'hA5A5_0000_0000_0000;
  logic [63:0] expData  = 64'hA5A5_0000_0000_0000;
  logic [63:0] popped;

  logic        sReq, sValid, sRe, sLast, sBusy;
  logic [31:0] sAddr, sWords;
  logic [8:0]  sLen;
  logic [63:0] sData;

  tempfifo_ddr_wr_sched #(
    .BURST_LEN (16),
    .ADDR_W    (32),
    .CNT_W     (11),
    .BASE_ADDR (32'h0),
    .MEM_WORDS (32'd32)
  ) dut (
    .digiclk_i       (digiclk_i),
    .reset           (reset),
    .enable_i        (enable_i),
    .restart_i       (restart_i),
    .flush_i         (flush_i),
    .tempfifo_rdcnt  (tempfifo_rdcnt),
    .tempfifo_empty  (tempfifo_empty),
    .tempfifo_data   (tempfifo_data),
    .tempfifo_re     (tempfifo_re),
    .wr_req_o        (wr_req_o),
    .wr_addr_o       (wr_addr_o),
    .wr_len_o        (wr_len_o),
    .wr_ack_i        (wr_ack_i),
    .wr_valid_o      (wr_valid_o),
    .wr_data_o       (wr_data_o),
    .wr_ready_i      (wr_ready_i),
    .wr_done_i       (wr_done_i),
    .last_write_o    (last_write_o),
    .words_written_o (words_written_o),
    .busy_o          (busy_o)
  );

  initial begin
    digiclk_i = 1'b0;
    forever #5 digiclk_i = ~digiclk_i;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic updateFifo();
    tempfifo_rdcnt = 11'(fifoQ.size());
    tempfifo_empty = fifoStall || (fifoQ.size() == 0);
    tempfifo_data  = (fifoQ.size() != 0) ? fifoQ[0] : 64'h0;
  endtask

  // Loads n sequentially numbered words into the FIFO model.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      fifoQ.push_back(nextPush);
      nextPush = nextPush + 64'd1;
    end
    updateFifo();
  endtask

  // Samples outputs mid-cycle, then pops the FIFO model if a read was seen.
  task automatic tick();
    @(negedge digiclk_i);
    sReq   = wr_req_o;
    sAddr  = wr_addr_o;
    sLen   = wr_len_o;
    sValid = wr_valid_o;
    sData  = wr_data_o;
    sRe    = tempfifo_re;
    sLast  = last_write_o;
    sBusy  = busy_o;
    sWords = words_written_o;
    @(posedge digiclk_i);
    #1;
    if (sRe && fifoQ.size() != 0) popped = fifoQ.pop_front();
    updateFifo();
  endtask

  task automatic runBurst(input int ackDelay, input int stallAt, input int stallLen,
                          output logic [31:0] reqAddr, output int reqLen, output int reqCycles,
                          output int beats, output int reCount, output int lowCycles,
                          output logic dataOk, output logic reqClean);
    int phase = 0;
    int cyc = 0;
    int respWait = 0;
    int stallCnt = 0;
    logic stallDone = 1'b0;
    reqAddr = '0; reqLen = 0; reqCycles = 0; beats = 0; reCount = 0; lowCycles = 0;
    dataOk = 1'b1; reqClean = 1'b1;
    wr_ack_i = (ackDelay == 0);
    wr_ready_i = 1'b1;
    wr_done_i = 1'b0;
    while (phase != 4 && cyc < 300) begin
      tick();
      cyc++;
      if (phase == 1 && !sReq) begin
        phase = 2;
        wr_ack_i = 1'b0;
      end
      if (phase == 0 && sReq) begin
        phase = 1;
        reqAddr = sAddr;
        reqLen = int'(sLen);
      end
      if (phase == 1) begin
        reqCycles++;
        if (sAddr !== reqAddr || sValid) reqClean = 1'b0;
        if (reqCycles == ackDelay) wr_ack_i = 1'b1;
      end else if (phase == 2) begin
        if (sValid) begin
          beats++;
          if (sData !== expData) dataOk = 1'b0;
          expData = expData + 64'd1;
        end else begin
          lowCycles++;
        end
        if (sRe) reCount++;
        if (beats == stallAt && !stallDone) begin
          stallCnt = stallLen;
          stallDone = 1'b1;
        end
        if (beats == reqLen) phase = 3;
      end else if (phase == 3) begin
        respWait++;
        if (respWait == 2) wr_done_i = 1'b1;
        else if (respWait == 3) begin
          wr_done_i = 1'b0;
          phase = 4;
        end
      end
      fifoStall = (stallCnt > 0);
      if (stallCnt > 0) stallCnt--;
      updateFifo();
    end
    checkOutput("burstCompletes", 64'(phase), 64'd4);
  endtask

  initial begin
    logic [31:0] rAddr;
    int rLen, rCyc, nBeats, nRe, nLow, reqSeen;
    logic okData, okReq;

    reset = 1'b1; enable_i = 1'b0; restart_i = 1'b0; flush_i = 1'b0;
    wr_ack_i = 1'b0; wr_ready_i = 1'b0; wr_done_i = 1'b0;
    updateFifo();
    @(posedge digiclk_i);
    @(posedge digiclk_i);
    #1;
    checkOutput("rstReq",   64'(wr_req_o), 64'd0);
    checkOutput("rstAddr",  64'(wr_addr_o), 64'h0);
    checkOutput("rstLen",   64'(wr_len_o), 64'd16);
    checkOutput("rstValid", 64'(wr_valid_o), 64'd0);
    checkOutput("rstRe",    64'(tempfifo_re), 64'd0);
    checkOutput("rstLast",  64'(last_write_o), 64'd0);
    checkOutput("rstWords", 64'(words_written_o), 64'd0);
    checkOutput("rstBusy",  64'(busy_o), 64'd0);
    reset = 1'b0;

    $display("[TB] basic burst");
    applyStimulus(16);
    enable_i = 1'b1;
    runBurst(0, -1, 0, rAddr, rLen, rCyc, nBeats, nRe, nLow, okData, okReq);
    checkOutput("t1Addr",  64'(rAddr), 64'h0);
    checkOutput("t1Len",   64'(rLen), 64'd16);
    checkOutput("t1Beats", 64'(nBeats), 64'd16);
    checkOutput("t1Re",    64'(nRe), 64'd16);
    checkOutput("t1Data",  64'(okData), 64'd1);
    tick();
    checkOutput("t1Words", 64'(sWords), 64'd16);
    checkOutput("t1Next",  64'(sAddr), 64'h80);
    checkOutput("t1Last",  64'(sLast), 64'd0);
    checkOutput("t1Busy",  64'(sBusy), 64'd0);

    $display("[TB] mid-burst stall, region fills");
    applyStimulus(16);
    runBurst(0, 5, 3, rAddr, rLen, rCyc, nBeats, nRe, nLow, okData, okReq);
    checkOutput("t2Addr",  64'(rAddr), 64'h80);
    checkOutput("t2Beats", 64'(nBeats), 64'd16);
    checkOutput("t2Low",   64'(nLow), 64'd3);
    checkOutput("t2Data",  64'(okData), 64'd1);
    tick();
    checkOutput("t3Last",  64'(sLast), 64'd1);
    checkOutput("t3Words", 64'(sWords), 64'd32);
    checkOutput("t3Addr",  64'(sAddr), 64'h100);

    applyStimulus(16);
    reqSeen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sReq) reqSeen++;
    end
    checkOutput("t3NoReq", 64'(reqSeen), 64'd0);
    enable_i = 1'b0;
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    tick();
    checkOutput("t3RstLast",  64'(sLast), 64'd0);
    checkOutput("t3RstAddr",  64'(sAddr), 64'h0);
    checkOutput("t3RstWords", 64'(sWords), 64'd0);

    $display("[TB] delayed ack");
    enable_i = 1'b1;
    runBurst(5, -1, 0, rAddr, rLen, rCyc, nBeats, nRe, nLow, okData, okReq);
    checkOutput("t5Addr",    64'(rAddr), 64'h0);
    checkOutput("t5ReqCyc",  64'(rCyc), 64'd6);
    checkOutput("t5ReqHold", 64'(okReq), 64'd1);
    checkOutput("t5Beats",   64'(nBeats), 64'd16);
    checkOutput("t5Data",    64'(okData), 64'd1);
    tick();
    checkOutput("t5Words", 64'(sWords), 64'd16);
    checkOutput("t5Next",  64'(sAddr), 64'h80);

    $display("[TB] reset mid-burst");
    applyStimulus(16);
    wr_ack_i = 1'b1;
    wr_ready_i = 1'b1;
    nBeats = 0;
    for (int i = 0; i < 100 && nBeats < 8; i++) begin
      tick();
      if (sValid) begin
        nBeats++;
        expData = expData + 64'd1;
      end
    end
    checkOutput("t4Beat8", 64'(nBeats), 64'd8);
    reset = 1'b1;
    #1;
    checkOutput("t4Req",   64'(wr_req_o), 64'd0);
    checkOutput("t4Valid", 64'(wr_valid_o), 64'd0);
    checkOutput("t4Re",    64'(tempfifo_re), 64'd0);
    checkOutput("t4Addr",  64'(wr_addr_o), 64'h0);
    checkOutput("t4Words", 64'(words_written_o), 64'd0);
    checkOutput("t4Busy",  64'(busy_o), 64'd0);
    @(posedge digiclk_i);
    @(posedge digiclk_i);
    #1;
    reset = 1'b0;
    applyStimulus(8);
    runBurst(0, -1, 0, rAddr, rLen, rCyc, nBeats, nRe, nLow, okData, okReq);
    checkOutput("t4ReAddr", 64'(rAddr), 64'h0);
    checkOutput("t4ReBeats", 64'(nBeats), 64'd16);
    checkOutput("t4ReData", 64'(okData), 64'd1);
    tick();
    checkOutput("t4ReWords", 64'(sWords), 64'd16);

    $display("[TB] partial flush");
    applyStimulus(5);
    flush_i = 1'b1;
`ifdef TEMPFIFO_FLUSH_EN
    runBurst(0, -1, 0, rAddr, rLen, rCyc, nBeats, nRe, nLow, okData, okReq);
    checkOutput("t6Addr",  64'(rAddr), 64'h80);
    checkOutput("t6Len",   64'(rLen), 64'd5);
    checkOutput("t6Beats", 64'(nBeats), 64'd5);
    checkOutput("t6Data",  64'(okData), 64'd1);
    tick();
    checkOutput("t6Next",  64'(sAddr), 64'hA8);
    checkOutput("t6Words", 64'(sWords), 64'd21);
    checkOutput("t6Last",  64'(sLast), 64'd1);
`else
    reqSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sReq) reqSeen++;
    end
    checkOutput("t6NoReq", 64'(reqSeen), 64'd0);
    checkOutput("t6Words", 64'(sWords), 64'd16);
    checkOutput("t6Busy",  64'(sBusy), 64'd0);
`endif
    flush_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
